// File: rtl/dma_chk_pkg.sv
// Shared types and helpers for the DMA burst integrity checker.
package dma_chk_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } chk_state_e;

  typedef enum logic {
    ABORT_ACCEPT = 1'b0,
    ABORT_REJECT = 1'b1
  } abort_mode_e;

  // Saturating add; callers pass the all-ones value of their counter width as max.
  function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                          input logic [31:0] inc,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, cnt} + {1'b0, inc};
    if (sum > {1'b0, max}) return max;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/dma_burst_chk_ch.sv
// One channel of the burst checker: request edge detect, IDLE/CHECK FSM,
// burst length counter, registered result pulses and sticky flags.
module dma_burst_chk_ch
  import dma_chk_pkg::*;
#(
  parameter int BURST_LEN = 100
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_chk_en,
  input  logic       i_abort_mode,
  input  logic       i_clear,
  input  logic       i_dma_req,
  input  logic       i_dt,
  input  logic       i_done,
  output chk_state_e o_state,
  output logic       o_res_pass,
  output logic       o_res_fail,
  output logic       o_pass_pulse,
  output logic       o_fail_pulse,
  output logic       o_err_sticky,
  output logic       o_ovl_sticky
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

  chk_state_e    r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          r_req_q;
  logic          r_pass, r_fail, r_err, r_ovl;
  logic          w_rise, w_pass, w_fail, w_ovl_set;

  assign w_rise    = i_dma_req & ~r_req_q;
  assign w_ovl_set = w_rise & (r_state == CHECK);

  // Resolution priority: enable, then done, then a dropped transfer, then burst complete.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_pass     = 1'b0;
    w_fail     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise && i_chk_en) begin
          w_state_nx = CHECK;
          w_cnt_nx   = '0;
        end
      end
      CHECK: begin
        if (!i_chk_en) begin
          w_state_nx = IDLE;
        end else if (i_done) begin
          w_state_nx = IDLE;
          if (abort_mode_e'(i_abort_mode) == ABORT_REJECT) w_fail = 1'b1;
          else                                             w_pass = 1'b1;
        end else if (!i_dt) begin
          w_state_nx = IDLE;
          w_fail     = 1'b1;
        end else if (r_cnt == LAST) begin
          w_state_nx = IDLE;
          w_pass     = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req_q <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
      r_err   <= 1'b0;
      r_ovl   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_req_q <= i_dma_req;
      r_pass  <= w_pass;
      r_fail  <= w_fail;
      // Clear-then-set so an event landing on the clear cycle is kept.
      r_err   <= (r_err & ~i_clear) | w_fail;
      r_ovl   <= (r_ovl & ~i_clear) | w_ovl_set;
    end
  end

  assign o_state      = r_state;
  assign o_res_pass   = w_pass;
  assign o_res_fail   = w_fail;
  assign o_pass_pulse = r_pass;
  assign o_fail_pulse = r_fail;
  assign o_err_sticky = r_err;
  assign o_ovl_sticky = r_ovl;

endmodule

// File: rtl/dma_burst_checker.sv
// Multi-channel DMA burst integrity monitor: per-channel checkers plus
// saturating aggregate pass/fail statistics.
module dma_burst_checker
  import dma_chk_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int BURST_LEN = 100,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chk_en,
  input  logic              abort_mode,
  input  logic              clear_stats,
  input  logic [NUM_CH-1:0] dma_req,
  input  logic [NUM_CH-1:0] data_transfer,
  input  logic [NUM_CH-1:0] done,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] pass_pulse,
  output logic [NUM_CH-1:0] fail_pulse,
  output logic [NUM_CH-1:0] err_sticky,
  output logic [NUM_CH-1:0] overlap_sticky,
  output logic [STAT_W-1:0] pass_cnt,
  output logic [STAT_W-1:0] fail_cnt
);

  localparam int PW = $clog2(NUM_CH + 1);
  localparam logic [31:0] STAT_MAX = 32'((64'd1 << STAT_W) - 64'd1);

  chk_state_e        w_state [NUM_CH];
  logic [NUM_CH-1:0] w_res_pass, w_res_fail;
  logic [PW-1:0]     w_pass_pop, w_fail_pop;
  logic [STAT_W-1:0] r_pass_cnt, r_fail_cnt;
  logic [STAT_W-1:0] w_pass_base, w_fail_base, w_pass_nx, w_fail_nx;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dma_burst_chk_ch #(.BURST_LEN(BURST_LEN)) u_ch (
      .i_clk        (clk),
      .i_rst_n      (reset_n),
      .i_chk_en     (chk_en),
      .i_abort_mode (abort_mode),
      .i_clear      (clear_stats),
      .i_dma_req    (dma_req[g]),
      .i_dt         (data_transfer[g]),
      .i_done       (done[g]),
      .o_state      (w_state[g]),
      .o_res_pass   (w_res_pass[g]),
      .o_res_fail   (w_res_fail[g]),
      .o_pass_pulse (pass_pulse[g]),
      .o_fail_pulse (fail_pulse[g]),
      .o_err_sticky (err_sticky[g]),
      .o_ovl_sticky (overlap_sticky[g])
    );
    assign busy[g] = (w_state[g] == CHECK);
  end

  always_comb begin
    w_pass_pop = '0;
    w_fail_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pass_pop = w_pass_pop + PW'(w_res_pass[i]);
      w_fail_pop = w_fail_pop + PW'(w_res_fail[i]);
    end
    w_pass_base = clear_stats ? '0 : r_pass_cnt;
    w_fail_base = clear_stats ? '0 : r_fail_cnt;
    w_pass_nx   = STAT_W'(sat_add(32'(w_pass_base), 32'(w_pass_pop), STAT_MAX));
    w_fail_nx   = STAT_W'(sat_add(32'(w_fail_base), 32'(w_fail_pop), STAT_MAX));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_pass_cnt <= w_pass_nx;
      r_fail_cnt <= w_fail_nx;
    end
  end

  assign pass_cnt = r_pass_cnt;
  assign fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_dma_burst_checker.sv
// Bench for dma_burst_checker: two instances (BURST_LEN=100/STAT_W=16 and
// BURST_LEN=3/STAT_W=2) share stimulus and are scored against a reference model.
module tb_dma_burst_checker;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       chk_en = 1'b0;
  logic       abort_mode = 1'b0;
  logic       clear_stats = 1'b0;
  logic [3:0] dma_req = '0;
  logic [3:0] data_transfer = '0;
  logic [3:0] done = '0;

  logic [3:0]  l_busy, l_pass, l_fail, l_err, l_ovl;
  logic [15:0] l_pc, l_fc;
  logic [3:0]  s_busy, s_pass, s_fail, s_err, s_ovl;
  logic [1:0]  s_pc, s_fc;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected-output scoreboard entries: busy|pass|fail|err|ovl|pass_cnt|fail_cnt
  logic [51:0] exp_q_l[$];
  logic [51:0] exp_q_s[$];

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  dma_burst_checker #(.NUM_CH(4), .BURST_LEN(100), .STAT_W(16)) dut_l (
    .clk(clk), .reset_n(reset_n), .chk_en(chk_en), .abort_mode(abort_mode),
    .clear_stats(clear_stats), .dma_req(dma_req), .data_transfer(data_transfer),
    .done(done), .busy(l_busy), .pass_pulse(l_pass), .fail_pulse(l_fail),
    .err_sticky(l_err), .overlap_sticky(l_ovl), .pass_cnt(l_pc), .fail_cnt(l_fc)
  );

  dma_burst_checker #(.NUM_CH(4), .BURST_LEN(3), .STAT_W(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .chk_en(chk_en), .abort_mode(abort_mode),
    .clear_stats(clear_stats), .dma_req(dma_req), .data_transfer(data_transfer),
    .done(done), .busy(s_busy), .pass_pulse(s_pass), .fail_pulse(s_fail),
    .err_sticky(s_err), .overlap_sticky(s_ovl), .pass_cnt(s_pc), .fail_cnt(s_fc)
  );

  // ---------------- reference model ----------------
  bit         m_in   [2][4];
  int         m_seen [2][4];
  bit         m_rq   [2][4];
  logic [3:0] m_err  [2];
  logic [3:0] m_ovl  [2];
  int         m_pc   [2];
  int         m_fc   [2];

  function automatic logic [51:0] pk(input logic [3:0] b, input logic [3:0] p,
                                     input logic [3:0] f, input logic [3:0] e,
                                     input logic [3:0] o, input logic [15:0] pc,
                                     input logic [15:0] fc);
    return {b, p, f, e, o, pc, fc};
  endfunction

  // One cycle of the rules: a burst is a sequence of attempts; each attempt
  // collects transfers until it has BURST_LEN of them or something ends it.
  task automatic model_step(input int k);
    int bl, mx;
    logic [3:0] pv, fv, os, bz;
    bit rise;
    bl = (k == 0) ? 100 : 3;
    mx = (k == 0) ? 65535 : 3;
    pv = '0; fv = '0; os = '0; bz = '0;
    if (!reset_n) begin
      for (int c = 0; c < 4; c++) begin
        m_in[k][c] = 0; m_seen[k][c] = 0; m_rq[k][c] = 0;
      end
      m_err[k] = '0; m_ovl[k] = '0; m_pc[k] = 0; m_fc[k] = 0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        rise = dma_req[c] && !m_rq[k][c];
        if (m_in[k][c]) begin
          if (rise) os[c] = 1'b1;
          if (!chk_en) m_in[k][c] = 0;
          else if (done[c]) begin
            m_in[k][c] = 0;
            if (abort_mode) fv[c] = 1'b1; else pv[c] = 1'b1;
          end else if (!data_transfer[c]) begin
            m_in[k][c] = 0;
            fv[c] = 1'b1;
          end else begin
            m_seen[k][c]++;
            if (m_seen[k][c] == bl) begin
              m_in[k][c] = 0;
              pv[c] = 1'b1;
            end
          end
        end else if (rise && chk_en) begin
          m_in[k][c] = 1;
          m_seen[k][c] = 0;
        end
        m_rq[k][c] = dma_req[c];
        bz[c] = m_in[k][c];
      end
      if (clear_stats) begin
        m_pc[k] = 0; m_fc[k] = 0; m_err[k] = '0; m_ovl[k] = '0;
      end
      m_pc[k] = m_pc[k] + $countones(pv);
      if (m_pc[k] > mx) m_pc[k] = mx;
      m_fc[k] = m_fc[k] + $countones(fv);
      if (m_fc[k] > mx) m_fc[k] = mx;
      m_err[k] = m_err[k] | fv;
      m_ovl[k] = m_ovl[k] | os;
    end
    if (k == 0) exp_q_l.push_back(pk(bz, pv, fv, m_err[k], m_ovl[k], 16'(m_pc[k]), 16'(m_fc[k])));
    else        exp_q_s.push_back(pk(bz, pv, fv, m_err[k], m_ovl[k], 16'(m_pc[k]), 16'(m_fc[k])));
  endtask

  // ---------------- checking ----------------
  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all(input string pfx, input logic [51:0] a, input logic [51:0] e);
    cmp({pfx, "_busy"},     int'(a[51:48]), int'(e[51:48]));
    cmp({pfx, "_pass"},     int'(a[47:44]), int'(e[47:44]));
    cmp({pfx, "_fail"},     int'(a[43:40]), int'(e[43:40]));
    cmp({pfx, "_err"},      int'(a[39:36]), int'(e[39:36]));
    cmp({pfx, "_ovl"},      int'(a[35:32]), int'(e[35:32]));
    cmp({pfx, "_pass_cnt"}, int'(a[31:16]), int'(e[31:16]));
    cmp({pfx, "_fail_cnt"}, int'(a[15:0]),  int'(e[15:0]));
  endtask

  // Monitor: outputs settle after each posedge; pop and compare every cycle.
  initial begin
    logic [51:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q_l.size() > 0) begin
        e = exp_q_l.pop_front();
        cmp_all("l", pk(l_busy, l_pass, l_fail, l_err, l_ovl, l_pc, l_fc), e);
      end
      if (exp_q_s.size() > 0) begin
        e = exp_q_s.pop_front();
        cmp_all("s", pk(s_busy, s_pass, s_fail, s_err, s_ovl, {14'b0, s_pc}, {14'b0, s_fc}), e);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [3:0] req, input logic [3:0] dt, input logic [3:0] dn,
                      input logic en, input logic ab, input logic clr, input logic rst);
    @(negedge clk);
    dma_req = req; data_transfer = dt; done = dn;
    chk_en = en; abort_mode = ab; clear_stats = clr; reset_n = rst;
    model_step(0);
    model_step(1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] req, dt, dn;

    step(4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("reset_busy", int'(l_busy), 0);
    cmp("reset_pass_cnt", int'(l_pc), 0);
    idle(3);

    // ch0 full burst, ch1 drops transfer at 40, ch2 done at 30 (accept)
    step(4'b0111, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 100; c++) begin
      dt = {1'b0, c < 30, c < 40, 1'b1};
      dn = {1'b0, c == 30, 2'b0};
      step(4'b0, dt, dn, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    idle(3);
    cmp("t1_pass_cnt", int'(l_pc), 2);
    cmp("t1_fail_cnt", int'(l_fc), 1);
    cmp("t1_err", int'(l_err), 4'b0010);

    // ch2 done again, reject mode
    step(4'b0100, 4'b0, 4'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 30; c++)
      step(4'b0, {1'b0, c < 30, 2'b0}, {1'b0, c == 30, 2'b0}, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(3);
    cmp("t1r_fail_cnt", int'(l_fc), 2);
    cmp("t1r_err", int'(l_err), 4'b0110);

    // all four channels pass in the same cycle; small instance saturates
    step(4'b1111, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 100; c++) step(4'b0, 4'b1111, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    cmp("t2_pass_cnt", int'(l_pc), 6);
    cmp("t2_sat_pass_cnt", int'(s_pc), 3);

    // clear_stats on the same cycle as a fail resolution
    step(4'b0010, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 5; c++) step(4'b0, 4'b0010, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(2);
    cmp("t3_fail_cnt", int'(l_fc), 1);
    cmp("t3_err", int'(l_err), 4'b0010);
    cmp("t3_pass_cnt", int'(l_pc), 0);

    // async reset mid-check
    step(4'b0001, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 50; c++) step(4'b0, 4'b0001, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cmp("t4_busy_before", int'(l_busy), 4'b0001);
    step(4'b0, 4'b0001, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    cmp("t4_busy_reset", int'(l_busy), 0);
    cmp("t4_fail_cnt_reset", int'(l_fc), 0);
    cmp("t4_err_reset", int'(l_err), 0);
    idle(3);

    // chk_en drop mid-check: abandon without a report
    step(4'b0001, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 60; c++) step(4'b0, 4'b0001, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4'b0, 4'b0001, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    cmp("t5_busy", int'(l_busy), 0);
    cmp("t5_pass_cnt", int'(l_pc), 0);
    cmp("t5_fail_cnt", int'(l_fc), 0);

    // rise while busy: overlap flagged, original attempt still passes
    step(4'b1000, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 100; c++)
      step({c == 30, 3'b0}, 4'b1000, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    cmp("t6_pass_cnt", int'(l_pc), 1);
    cmp("t6_ovl", int'(l_ovl), 4'b1000);

    // randomized traffic
    req = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 24) == 0) req[c] = ~req[c];
        dt[c] = ($urandom_range(0, 999) < 995);
        dn[c] = ($urandom_range(0, 199) == 0);
      end
      step(req, dt, dn, $urandom_range(0, 499) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 299) == 0, $urandom_range(0, 1999) != 0);
    end
    idle(3);

    @(negedge clk);
    cmp("drain_l", exp_q_l.size(), 0);
    cmp("drain_s", exp_q_s.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
